// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch address map, exception codes and the
// types used by the instruction fetch unit.
package cpu_pkg;

  // Fetch address map
  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_LAST    = 32'h0000_6FFC;

  // Exception codes, shared with CP0 and the later-stage collectors
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Which source won the next-PC arbitration this cycle
  typedef enum logic [2:0] {
    NPC_EXC,
    NPC_ERET,
    NPC_HOLD,
    NPC_REDIRECT,
    NPC_SEQ
  } npc_sel_e;

  // Contents of the F/D pipeline register
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  excode;
    logic        valid;
  } fd_reg_t;

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC arbiter and instruction-fetch address check.
module ifu_npc
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VEC  = EXC_VECTOR,
  parameter logic [31:0] MEM_BASE = IM_BASE,
  parameter logic [31:0] MEM_LAST = IM_LAST
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] npc,
  output npc_sel_e    npc_sel,
  output logic        fetch_err
);

  // Priority select: exception, return, stall, redirect, sequential.
  // A redirect under stall is dropped; the D stage re-presents it.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    npc     = pc + 32'd4;
    npc_sel = NPC_SEQ;
    if (exc_req) begin
      npc     = EXC_VEC;
      npc_sel = NPC_EXC;
    end else if (eret) begin
      npc     = epc;
      npc_sel = NPC_ERET;
    end else if (stall) begin
      npc     = pc;
      npc_sel = NPC_HOLD;
    end else if (redirect) begin
      npc     = redirect_pc;
      npc_sel = NPC_REDIRECT;
    end
  end

  // AdEL: misaligned or outside the instruction memory window (unsigned).
  assign fetch_err = (pc[1:0] != 2'b00) || (pc < MEM_BASE) || (pc > MEM_LAST);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register feeding the combinational instruction
// memory, and the F/D pipeline register capturing the fetched instruction.
module ifu_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = cpu_pkg::PC_RESET,
  parameter logic [31:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR,
  parameter logic [31:0] IM_BASE    = cpu_pkg::IM_BASE,
  parameter logic [31:0] IM_LAST    = cpu_pkg::IM_LAST
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_instr,
  output logic [4:0]  fd_excode,
  output logic        fd_valid
);

  logic [31:0] pc_q;
  logic [31:0] npc;
  npc_sel_e    npc_sel;
  logic        fetch_err;
  fd_reg_t     fd_q;

  ifu_npc #(
    .EXC_VEC  (EXC_VECTOR),
    .MEM_BASE (IM_BASE),
    .MEM_LAST (IM_LAST)
  ) u_npc (
    .pc          (pc_q),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .exc_req     (exc_req),
    .eret        (eret),
    .epc         (epc),
    .npc         (npc),
    .npc_sel     (npc_sel),
    .fetch_err   (fetch_err)
  );

  // PC register: loads the arbitrated next PC every edge (hold is a source).
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state uses non-blocking assignments so all registers sample pre-edge values.
    if (!reset_n) pc_q <= PC_RESET;
    else          pc_q <= npc;
  end

  // F/D register: bubble on exception/return, hold on stall, else capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fd_q <= '0;
    end else begin
      case (npc_sel)
        NPC_EXC, NPC_ERET: begin
          fd_q.pc     <= npc;
          fd_q.instr  <= '0;
          fd_q.excode <= EXC_NONE;
          fd_q.valid  <= 1'b0;
        end
        NPC_HOLD: fd_q <= fd_q;
        default: begin
          fd_q.pc     <= pc_q;
          fd_q.instr  <= fetch_err ? 32'h0 : instr;
          fd_q.excode <= fetch_err ? EXC_ADEL : EXC_NONE;
          fd_q.valid  <= 1'b1;
        end
      endcase
    end
  end

  assign pc        = pc_q;
  assign fd_pc     = fd_q.pc;
  assign fd_instr  = fd_q.instr;
  assign fd_excode = fd_q.excode;
  assign fd_valid  = fd_q.valid;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: the driver pushes hand-computed expected
// state for the coming edge, a monitor pops and compares on the falling edge.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, redirect, exc_req, eret;
  logic [31:0] redirect_pc, epc;
  logic [31:0] pc, instr, fd_pc, fd_instr;
  logic [4:0]  fd_excode;
  logic        fd_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] fd_pc;
    logic [31:0] fd_instr;
    logic [4:0]  fd_excode;
    logic        fd_valid;
  } exp_t;

  exp_t sb[$];

  ifu_fetch dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .exc_req     (exc_req),
    .eret        (eret),
    .epc         (epc),
    .pc          (pc),
    .instr       (instr),
    .fd_pc       (fd_pc),
    .fd_instr    (fd_instr),
    .fd_excode   (fd_excode),
    .fd_valid    (fd_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory model: tagged word per address, one special word.
  assign instr = (pc == 32'h0000_3010) ? 32'h2408_0001 : {16'hAC00, pc[15:0]};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %08h want %08h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares the expectation due after the most recent edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        check("stale_expectation", 32'(e.cyc), 32'(cyc));
      end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check("pc",        pc,                e.pc);
        check("fd_pc",     fd_pc,             e.fd_pc);
        check("fd_instr",  fd_instr,          e.fd_instr);
        check("fd_excode", 32'(fd_excode),    32'(e.fd_excode));
        check("fd_valid",  32'(fd_valid),     32'(e.fd_valid));
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc,
                      input logic x, input logic er, input logic [31:0] ep,
                      input logic [31:0] e_pc, input logic [31:0] e_fpc,
                      input logic [31:0] e_fin, input logic [4:0] e_fex,
                      input logic e_fv);
    exp_t e;
    stall = s; redirect = r; redirect_pc = rpc;
    exc_req = x; eret = er; epc = ep;
    e.cyc = cyc + 1; e.pc = e_pc; e.fd_pc = e_fpc;
    e.fd_instr = e_fin; e.fd_excode = e_fex; e.fd_valid = e_fv;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic [31:0] e_pc, input logic [31:0] e_fpc,
                      input logic [31:0] e_fin, input logic [4:0] e_fex);
    step(0, 0, 32'h0, 0, 0, 32'h0, e_pc, e_fpc, e_fin, e_fex, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"},        pc,             32'h0000_3000);
    check({tag, "_fd_pc"},     fd_pc,          32'h0);
    check({tag, "_fd_instr"},  fd_instr,       32'h0);
    check({tag, "_fd_excode"}, 32'(fd_excode), 32'h0);
    check({tag, "_fd_valid"},  32'(fd_valid),  32'h0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    stall = 0; redirect = 0; redirect_pc = '0;
    exc_req = 0; eret = 0; epc = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_state("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Sequential fetch from reset
    idle(32'h3004, 32'h3000, 32'hAC00_3000, 5'd0);
    idle(32'h3008, 32'h3004, 32'hAC00_3004, 5'd0);
    idle(32'h300C, 32'h3008, 32'hAC00_3008, 5'd0);
    idle(32'h3010, 32'h300C, 32'hAC00_300C, 5'd0);
    // Stall three cycles at 3010: PC and F/D hold
    repeat (3) step(1, 0, 32'h0, 0, 0, 32'h0, 32'h3010, 32'h300C, 32'hAC00_300C, 5'd0, 1'b1);
    idle(32'h3014, 32'h3010, 32'h2408_0001, 5'd0);
    idle(32'h3018, 32'h3014, 32'hAC00_3014, 5'd0);
    idle(32'h301C, 32'h3018, 32'hAC00_3018, 5'd0);
    idle(32'h3020, 32'h301C, 32'hAC00_301C, 5'd0);
    // Redirect under stall is ignored, then taken
    step(1, 1, 32'h3100, 0, 0, 32'h0, 32'h3020, 32'h301C, 32'hAC00_301C, 5'd0, 1'b1);
    step(0, 1, 32'h3100, 0, 0, 32'h0, 32'h3100, 32'h3020, 32'hAC00_3020, 5'd0, 1'b1);
    idle(32'h3104, 32'h3100, 32'hAC00_3100, 5'd0);
    // Misaligned target
    step(0, 1, 32'h3102, 0, 0, 32'h0, 32'h3102, 32'h3104, 32'hAC00_3104, 5'd0, 1'b1);
    idle(32'h3106, 32'h3102, 32'h0, 5'd4);
    // Out-of-range target
    step(0, 1, 32'h7000, 0, 0, 32'h0, 32'h7000, 32'h3106, 32'h0, 5'd4, 1'b1);
    idle(32'h7004, 32'h7000, 32'h0, 5'd4);
    step(0, 1, 32'h3200, 0, 0, 32'h0, 32'h3200, 32'h7004, 32'h0, 5'd4, 1'b1);
    idle(32'h3204, 32'h3200, 32'hAC00_3200, 5'd0);
    // Exception beats stall and redirect
    step(1, 1, 32'h3300, 1, 0, 32'h0, 32'h4180, 32'h4180, 32'h0, 5'd0, 1'b0);
    idle(32'h4184, 32'h4180, 32'hAC00_4180, 5'd0);
    // Return
    step(0, 0, 32'h0, 0, 1, 32'h3040, 32'h3040, 32'h3040, 32'h0, 5'd0, 1'b0);
    idle(32'h3044, 32'h3040, 32'hAC00_3040, 5'd0);
    // Exception beats return; return beats stall
    step(0, 0, 32'h0, 1, 1, 32'h3040, 32'h4180, 32'h4180, 32'h0, 5'd0, 1'b0);
    step(1, 0, 32'h0, 0, 1, 32'h3050, 32'h3050, 32'h3050, 32'h0, 5'd0, 1'b0);
    idle(32'h3054, 32'h3050, 32'hAC00_3050, 5'd0);
    // Range boundaries: last legal word, one past it, one below base
    step(0, 1, 32'h6FFC, 0, 0, 32'h0, 32'h6FFC, 32'h3054, 32'hAC00_3054, 5'd0, 1'b1);
    idle(32'h7000, 32'h6FFC, 32'hAC00_6FFC, 5'd0);
    step(0, 1, 32'h2FFC, 0, 0, 32'h0, 32'h2FFC, 32'h7000, 32'h0, 5'd4, 1'b1);
    // Wrap-around from the top of the address space
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'h2FFC, 32'h0, 5'd4, 1'b1);
    idle(32'h0, 32'hFFFF_FFFC, 32'h0, 5'd4);
    idle(32'h4, 32'h0, 32'h0, 5'd4);
    drain();

    // Asynchronous reset pulse mid-cycle with a stalled redirect pending
    @(posedge clk);
    #2;
    stall = 1; redirect = 1; redirect_pc = 32'h5000;
    reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    #1;
    reset_n = 1'b1;
    stall = 0; redirect = 0;
    begin
      exp_t e;
      e.cyc = cyc + 1; e.pc = 32'h3004; e.fd_pc = 32'h3000;
      e.fd_instr = 32'hAC00_3000; e.fd_excode = 5'd0; e.fd_valid = 1'b1;
      sb.push_back(e);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: owns the PC register that drives the combinational instruction memory address. It captures the returned instruction into the F/D pipeline register. It arbitrates sequential fetch, D-stage branch/jump redirects, exception entry, `eret` return and pipeline stalls. It flags instruction-fetch address errors (AdEL) so the downstream exception logic can act on them.

## Interface
- `PC_RESET`, default 32'h0000_3000: PC after reset.
- `EXC_VECTOR`, default 32'h0000_4180: exception handler entry.
- `IM_BASE`, default 32'h0000_3000: lowest legal fetch address.
- `IM_LAST`, default 32'h0000_6FFC: highest legal fetch address (4096 words).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `stall`  in  1  — hold PC and F/D.
- `redirect`  in  1  — D-stage branch taken or jump.
- `redirect_pc`  in  32  — target for `redirect`.
- `exc_req`  in  1  — take exception.
- `eret`  in  1  — return from exception.
- `epc`  in  32  — return address for `eret`.
- `pc`  out  32  — current fetch address to instruction memory.
- `instr`  in  32  — instruction memory data for `pc` (same cycle).
- `fd_pc`  out  32  — PC of the instruction held in F/D.
- `fd_instr`  out  32  — instruction held in F/D.
- `fd_excode`  out  5  — 0 = none, 4 = AdEL.
- `fd_valid`  out  1  — F/D holds a real fetch (0 = bubble).

## Operation
- **Fetch check:** `fetch_err` = `pc[1:0] != 0` or `pc < IM_BASE` or `pc > IM_LAST` (unsigned compare).
- **Next-PC priority**, evaluated each cycle:
  1. `exc_req` → `EXC_VECTOR`
  2. `eret` → `epc`
  3. `stall` → `pc` (hold)
  4. `redirect` → `redirect_pc`
  5. otherwise `pc + 4`, modulo 2^32, no saturation.
- **F/D update**, same priority:
  - `exc_req` or `eret`: bubble. `fd_instr` = 0, `fd_excode` = 0, `fd_valid` = 0, `fd_pc` = new PC target.
  - `stall`: all F/D fields hold.
  - else: `fd_pc` = `pc`, `fd_valid` = 1.
    - If `fetch_err`: `fd_instr` = 0 (nop) and `fd_excode` = 4.
    - Else: `fd_instr` = `instr` and `fd_excode` = 0.
- **Delay slot:** a redirect takes effect on the PC after the slot. The slot instruction is already at `pc` when `redirect` is seen, so it is captured normally.
- **Redirect during stall:** ignored. The D stage re-presents the redirect once the stall drops.
- **Misaligned or out-of-range targets** (`redirect_pc`, `epc`) are loaded unchanged. The error surfaces through `fetch_err` on the following capture. The PC is never corrected.
- **`exc_req` and `eret` together:** `exc_req` wins.

## Timing
- **Reset** (asynchronous, while `reset_n` = 0): `pc` = `PC_RESET`, `fd_pc` = 0, `fd_instr` = 0, `fd_excode` = 0, `fd_valid` = 0.
- **Reset release:** the first capturing edge loads F/D from `PC_RESET`.
- **Reset asserted mid-stall or mid-redirect:** all state is dropped immediately. No pending redirect survives.
- **Registers:** `pc` and F/D update only on `clk` rising edge. `pc` is a register output with no combinational path from inputs.
- **Latency:**
  - Instruction memory read is combinational, so the instruction at `pc` appears in `fd_instr` one edge later.
  - A redirect seen in cycle N puts the target on `pc` in cycle N+1 and in F/D in cycle N+2.
- **Wrap-around:** `pc + 4` from 32'hFFFF_FFFC gives 0. It is flagged AdEL by range.

## Structure
- **Shared package `cpu_pkg`:**
  - `PC_RESET`, `EXC_VECTOR`, `IM_BASE`, `IM_LAST`
  - exception codes `EXC_NONE` = 5'd0 and `EXC_ADEL` = 5'd4, shared with CP0 and the later-stage exception collectors.
- **One sub-module `ifu_npc`:** purely combinational next-PC mux plus `fetch_err` check.
- **Top level** holds the PC register and the F/D register.

## Test plan
- **Reset:** hold `reset_n` = 0 for 3 cycles, release → `pc` = 3000 during reset. After 2 edges `pc` = 3008 and `fd_pc` = 3004 with `fd_valid` = 1.
- **Stall:** at `pc` = 3010, assert `stall` for 3 cycles with `instr` = 2408_0001 → `pc` stays 3010 and F/D holds its 300C contents. On release `fd_instr` = 2408_0001.
- **Redirect:**
  - Sequence 1: `redirect` = 1, `redirect_pc` = 3100 at `pc` = 3020 → `pc` = 3100 next cycle; `fd_pc` shows 3020, then 3100.
  - Sequence 2: same redirect with `stall` = 1 → ignored, `pc` stays 3020.
- **AdEL:**
  - `redirect_pc` = 3102 → next capture gives `fd_excode` = 4, `fd_instr` = 0, `fd_valid` = 1.
  - Repeat with `redirect_pc` = 7000 → same response, out of range.
- **Exception entry:** `exc_req` with `stall` = 1 and `redirect` = 1 simultaneously → `pc` = 4180, F/D bubble with `fd_pc` = 4180 and `fd_valid` = 0.
- **Return:**
  - `eret`, `epc` = 3040 → `pc` = 3040, F/D bubble.
  - `exc_req` and `eret` in the same cycle → `pc` = 4180.
  - Async `reset_n` pulse mid-cycle → all outputs at reset values before the next edge.
